// File: rtl/mem_access_sequencer_pkg.sv
// Shared types and helpers for the MEM-stage data-memory sequencer.
//   - Size encodings for mem_size.
//   - FSM state type.
//   - Byte-lane enable constants.
//   - Alignment, lane-enable and store-replication helpers.
// Byte order is big-endian: byte offset 0 sits in bits [31:24].
package mem_access_sequencer_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;  // 2'b11 is also handled as a word

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } state_e;

    localparam logic [3:0] BE_BYTE0   = 4'b1000;  // byte at offset 0; shift right by offset
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        case (size)
            MEM_BYTE: mis = 1'b0;
            MEM_HALF: mis = lane[0];
            default:  mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            MEM_BYTE: be = BE_BYTE0 >> lane;
            MEM_HALF: be = lane[1] ? BE_HALF_LO : BE_HALF_HI;
            default:  be = BE_WORD;
        endcase
        return be;
    endfunction

    // Replicate right-justified store data so every lane the enables pick carries it.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] r;
        case (size)
            MEM_BYTE: r = {4{data[7:0]}};
            MEM_HALF: r = {2{data[15:0]}};
            default:  r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Data-memory request/ready bus between the MEM-stage sequencer and memory.
//   req    request strobe (sequencer -> memory)
//   we     write enable
//   addr   word-aligned byte address
//   be     byte enables, bit 3 = bits [31:24]
//   wdata  store data already replicated into lanes
//   ready  memory completes the current request (memory -> sequencer)
//   rdata  read word, valid with ready
interface mem_access_sequencer_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              ready;
    logic [31:0]       rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ready, rdata
    );

endinterface

// File: rtl/mem_access_sequencer_load_aligner.sv
// Combinational load aligner: picks the addressed lane(s) out of the memory
// read word, right-justifies them and sign- or zero-extends to 32 bits.
//   rdata    in   32  memory read word
//   size     in    2  access size (byte/half/word)
//   se       in    1  1 = sign-extend, 0 = zero-extend
//   lane     in    2  byte offset addr[1:0]
//   ld_word  out  32  aligned, extended load result
module mem_load_aligner
    import mem_access_sequencer_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  size,
    input  logic        se,
    input  logic [1:0]  lane,
    output logic [31:0] ld_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane)
            2'b00:   byte_sel = rdata[31:24];
            2'b01:   byte_sel = rdata[23:16];
            2'b10:   byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = lane[1] ? rdata[15:0] : rdata[31:16];

        case (size)
            MEM_BYTE: ld_word = {{24{se & byte_sel[7]}}, byte_sel};
            MEM_HALF: ld_word = {{16{se & half_sel[15]}}, half_sel};
            default:  ld_word = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// MEM-stage data-memory sequencer. Issues one request/ready transaction per
// aligned memory instruction, stalls the pipeline until memory answers, then
// returns aligned and extended load data with a one-cycle ld_valid pulse.
// Misaligned accesses raise misalign_exc and never reach memory.
//
// Optional feature: define MEM_TIMEOUT_EN to add a wait counter and an ERR
// state; after TIMEOUT_CYCLES ACCESS cycles without ready the transaction is
// dropped and timeout_exc pulses. Without it ACCESS waits indefinitely.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   mem_en/rw/size/se       decoded MEM-stage controls (sampled in IDLE only)
//   addr, wdata             effective byte address, right-justified store data
//   dm                      data-memory bus (master side)
//   stall                   freeze IF/ID/EX/MEM pipeline registers
//   ld_data, ld_valid       load result and its one-cycle valid pulse
//   misalign_exc            one-cycle pulse on a misaligned access
//   timeout_exc             one-cycle pulse on a memory timeout
module mem_access_sequencer
    import mem_access_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          mem_en,
    input  logic                          mem_rw,
    input  logic [1:0]                    mem_size,
    input  logic                          mem_se,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [31:0]                   wdata,
    mem_access_sequencer_if.master        dm,
    output logic                          stall,
    output logic [31:0]                   ld_data,
    output logic                          ld_valid,
    output logic                          misalign_exc,
    output logic                          timeout_exc
);

    state_e              state_q;
    logic                req_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          be_q;
    logic [31:0]         wdata_q;
    logic [1:0]          size_q;
    logic                se_q;
    logic [1:0]          lane_q;
    logic [31:0]         ld_data_q;
    logic                ld_valid_q;
    logic                misalign_q;
    logic                misaligned;
    logic                issue;
    logic [31:0]         ld_word;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic                timeout_q;
`endif

    assign misaligned = is_misaligned(mem_size, addr[1:0]);
    assign issue      = (state_q == IDLE) && mem_en && !misaligned;

    // Stall goes high combinationally in the issue cycle so the instruction
    // stays in MEM while its request is outstanding.
    assign stall = issue || (state_q == ACCESS);

    mem_load_aligner u_load_aligner (
        .rdata   (dm.rdata),
        .size    (size_q),
        .se      (se_q),
        .lane    (lane_q),
        .ld_word (ld_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= 32'h0;
            size_q     <= MEM_BYTE;
            se_q       <= 1'b0;
            lane_q     <= 2'b00;
            ld_data_q  <= 32'h0;
            ld_valid_q <= 1'b0;
            misalign_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            // Single-cycle pulses default low.
            ld_valid_q <= 1'b0;
            misalign_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (mem_en) begin
                        if (misaligned) begin
                            misalign_q <= 1'b1;
                        end else begin
                            req_q   <= 1'b1;
                            we_q    <= mem_rw;
                            addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                            be_q    <= lane_enables(mem_size, addr[1:0]);
                            wdata_q <= store_lanes(mem_size, wdata);
                            size_q  <= mem_size;
                            se_q    <= mem_se;
                            lane_q  <= addr[1:0];
`ifdef MEM_TIMEOUT_EN
                            wait_cnt_q <= '0;
`endif
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // Ready wins even on the cycle the timeout limit is reached.
                    if (dm.ready) begin
                        if (!we_q) begin
                            ld_data_q <= ld_word;
                        end
                        ld_valid_q <= !we_q;
                        req_q      <= 1'b0;
                        state_q    <= DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        req_q     <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= ERR;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
`endif
                end
                // No back-to-back issue: the next instruction is sampled in IDLE.
                DONE:    state_q <= IDLE;
`ifdef MEM_TIMEOUT_EN
                ERR:     state_q <= IDLE;
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dm.req       = req_q;
    assign dm.we        = we_q;
    assign dm.addr      = addr_q;
    assign dm.be        = be_q;
    assign dm.wdata     = wdata_q;
    assign ld_data      = ld_data_q;
    assign ld_valid     = ld_valid_q;
    assign misalign_exc = misalign_q;
`ifdef MEM_TIMEOUT_EN
    assign timeout_exc  = timeout_q;
`else
    assign timeout_exc  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: directed cases followed by
// random transactions, each checked against a byte-level big-endian model.
module tb_mem_access_sequencer;

    import mem_access_sequencer_pkg::*;

`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 1000000;
`endif

    logic        clk;
    logic        reset_n;
    logic        mem_en;
    logic        mem_rw;
    logic [1:0]  mem_size;
    logic        mem_se;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        misalign_exc;
    logic        timeout_exc;

    int          n_tests;
    int          n_fail;
    logic [31:0] last_ld;

    mem_access_sequencer_if #(.ADDR_W(32)) dm ();

    mem_access_sequencer #(
        .ADDR_W(32)
`ifdef MEM_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem_en       (mem_en),
        .mem_rw       (mem_rw),
        .mem_size     (mem_size),
        .mem_se       (mem_se),
        .addr         (addr),
        .wdata        (wdata),
        .dm           (dm),
        .stall        (stall),
        .ld_data      (ld_data),
        .ld_valid     (ld_valid),
        .misalign_exc (misalign_exc),
        .timeout_exc  (timeout_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
        end
    endtask

    // ---- reference model: memory as four big-endian bytes ----
    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit misal(input logic [1:0] s, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(s)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] s, input logic [31:0] a);
        logic [3:0] be = 4'b0000;
        int n = nbytes(s);
        int off = int'(a[1:0]);
        for (int i = 0; i < n; i++) be[3 - (off + i)] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [1:0] s, input logic [31:0] wd);
        logic [31:0] r = 32'h0;
        int n = nbytes(s);
        for (int k = 0; k < 4; k++) r[31 - 8 * k -: 8] = 8'(wd >> (8 * (n - 1 - (k % n))));
        return r;
    endfunction

    function automatic logic [31:0] exp_ld(input logic [1:0] s, input logic se,
                                           input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v = 32'h0;
        int n = nbytes(s);
        int off = int'(a[1:0]);
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(rd[31 - 8 * (off + i) -: 8]);
        if (n < 4 && se && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    // One full instruction: issue cycle, ACCESS cycles, then DONE / ERR.
    // wt = ACCESS cycles without ready before ready arrives.
    task automatic do_txn(input logic rw, input logic [1:0] sz, input logic se,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int wt);
        bit mis = misal(sz, a);
        bit tmo = (wt >= TO);
        int acc = (wt + 1 < TO) ? wt + 1 : TO;
        int n_st = 0;

        mem_en   = 1'b1;
        mem_rw   = rw;
        mem_size = sz;
        mem_se   = se;
        addr     = a;
        wdata    = wd;
        dm.ready = 1'($urandom_range(0, 1));  // ignored in IDLE
        dm.rdata = $urandom;
        @(negedge clk);
        check("issue_req", 32'(dm.req), 32'd0);
        check("issue_stall", 32'(stall), 32'(!mis));
        check("issue_ldv", 32'(ld_valid), 32'd0);
        check("issue_mis", 32'(misalign_exc), 32'd0);
        check("issue_tmo", 32'(timeout_exc), 32'd0);
        if (stall) n_st++;
        @(posedge clk); #1;

        if (mis) begin
            mem_en   = 1'b0;
            dm.ready = 1'b0;
            @(negedge clk);
            check("mis_pulse", 32'(misalign_exc), 32'd1);
            check("mis_req", 32'(dm.req), 32'd0);
            check("mis_stall", 32'(stall), 32'd0);
            @(posedge clk); #1;
            return;
        end

        for (int c = 0; c < acc; c++) begin
            // Inputs are don't-care while stalled.
            mem_en   = 1'($urandom_range(0, 1));
            mem_rw   = 1'($urandom_range(0, 1));
            mem_size = 2'($urandom_range(0, 3));
            addr     = $urandom;
            wdata    = $urandom;
            dm.ready = (!tmo && c == acc - 1);
            dm.rdata = dm.ready ? rd : $urandom;
            @(negedge clk);
            check("acc_req", 32'(dm.req), 32'd1);
            check("acc_stall", 32'(stall), 32'd1);
            check("acc_we", 32'(dm.we), 32'(rw));
            check("acc_addr", dm.addr, {a[31:2], 2'b00});
            check("acc_be", 32'(dm.be), 32'(exp_be(sz, a)));
            check("acc_wdata", dm.wdata, exp_wd(sz, wd));
            check("acc_ldv", 32'(ld_valid), 32'd0);
            if (stall) n_st++;
            @(posedge clk); #1;
        end

        mem_en   = 1'b0;
        dm.ready = 1'($urandom_range(0, 1));  // ignored outside ACCESS
        dm.rdata = $urandom;
        if (!tmo && !rw) last_ld = exp_ld(sz, se, a, rd);
        @(negedge clk);
        check("end_req", 32'(dm.req), 32'd0);
        check("end_stall", 32'(stall), 32'd0);
        check("end_ldv", 32'(ld_valid), 32'(!tmo && !rw));
        check("end_tmo", 32'(timeout_exc), 32'(tmo));
        check("end_ldata", ld_data, last_ld);
        check("stall_cycles", 32'(n_st), 32'(1 + acc));
        @(posedge clk); #1;
        dm.ready = 1'b0;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        last_ld  = 32'h0;
        reset_n  = 1'b0;
        mem_en   = 1'b0;
        mem_rw   = 1'b0;
        mem_size = 2'b00;
        mem_se   = 1'b0;
        addr     = 32'h0;
        wdata    = 32'h0;
        dm.ready = 1'b0;
        dm.rdata = 32'h0;
        #1;
        check("rst_req", 32'(dm.req), 32'd0);
        check("rst_we", 32'(dm.we), 32'd0);
        check("rst_be", 32'(dm.be), 32'd0);
        check("rst_addr", dm.addr, 32'd0);
        check("rst_wdata", dm.wdata, 32'd0);
        check("rst_ldata", ld_data, 32'd0);
        check("rst_ldv", 32'(ld_valid), 32'd0);
        check("rst_mis", 32'(misalign_exc), 32'd0);
        check("rst_tmo", 32'(timeout_exc), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // LBU at 0x3, zero wait.
        do_txn(1'b0, MEM_BYTE, 1'b0, 32'h0000_0003, 32'h0, 32'h1122_33F4, 0);
        check("lbu_value", ld_data, 32'h0000_00F4);
        // LB at 0x1.
        do_txn(1'b0, MEM_BYTE, 1'b1, 32'h0000_0001, 32'h0, 32'h1280_0000, 0);
        check("lb_value", ld_data, 32'hFFFF_FF80);
        // SH at 0x12: load result must be left untouched.
        do_txn(1'b1, MEM_HALF, 1'b0, 32'h0000_0012, 32'hDEAD_BEEF, 32'h0, 1);
        check("sh_keeps_ld", ld_data, 32'hFFFF_FF80);
        // Misaligned LW at 0x6.
        do_txn(1'b0, MEM_WORD, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 0);
        // LW with ready after five wait cycles.
        do_txn(1'b0, MEM_WORD, 1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 5);

        // Second LW abandoned by reset mid-ACCESS.
        mem_en   = 1'b1;
        mem_rw   = 1'b0;
        mem_size = MEM_WORD;
        addr     = 32'h0000_0040;
        @(posedge clk); #1;
        mem_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(dm.req), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_addr", dm.addr, 32'd0);
        check("mid_rst_be", 32'(dm.be), 32'd0);
        check("mid_rst_ldata", ld_data, 32'd0);
        check("mid_rst_tmo", 32'(timeout_exc), 32'd0);
        last_ld = 32'h0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_req", 32'(dm.req), 32'd0);
        check("post_rst_stall", 32'(stall), 32'd0);
        check("post_rst_mis", 32'(misalign_exc), 32'd0);
        @(posedge clk); #1;

        // Long wait: completes normally, or times out when the counter is built in.
        do_txn(1'b0, MEM_HALF, 1'b1, 32'h0000_0052, 32'h0, 32'h0000_9ABC, 10);
        // Ready arriving exactly on the limit cycle.
        do_txn(1'b0, MEM_WORD, 1'b0, 32'h0000_0060, 32'h0, 32'h1357_9BDF, 3);

        for (int t = 0; t < 80; t++) begin
            do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 5)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
